// File: rtl/vpf_count_pkg.sv
// Shared constants and helpers for the VPF hit-count pipeline.
// count1s does the per-group popcount; the remaining constant functions size
// the adder tree (group count, tree depth, per-level group count and width).
package vpf_count_pkg;

    localparam int GRP_W = 32'sd6;   // VPF bits per popcount group
    localparam int PC_W  = 32'sd3;   // width of a 6-bit popcount

    // Number of set bits in one 6-bit group.
    function automatic logic [2:0] count1s(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 32'sd0; i < 32'sd6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Width needed to hold any count from 0 to size inclusive.
    function automatic int cnt_width(input int size);
        return $clog2(size + 32'sd1);
    endfunction

    // Pairwise-add levels needed to reduce ng groups to one (0 when ng is already 1).
    function automatic int tree_levels(input int ng);
        if (ng <= 32'sd1) begin
            return 32'sd0;
        end else begin
            return $clog2(ng);
        end
    endfunction

    // Partial sums present after lvl pairwise-add levels (odd leftovers carried up).
    function automatic int grp_count(input int ng, input int lvl);
        int n;
        n = ng;
        for (int i = 32'sd0; i < lvl; i++) begin
            n = (n + 32'sd1) / 32'sd2;
        end
        return n;
    endfunction

    // Partial-sum width after lvl levels: grows one bit per level, capped at cntw.
    function automatic int lvl_width(input int lvl, input int cntw);
        int w;
        w = PC_W + lvl;
        if (w > cntw) begin
            return cntw;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/vpf_count_pipe_add_level.sv
// One registered level of the popcount adder tree.
// Adds neighbouring partial sums pairwise; an odd trailing input is paired
// with an implicit zero by padding the input bus. The sum width grows by one
// bit but never beyond W_CAP, the width of the final count, which already
// covers the largest value the tree can produce.
module vpf_add_level #(
    parameter  int N_IN  = 2,
    parameter  int W_IN  = 3,
    parameter  int W_CAP = 10,
    localparam int N_OUT = (N_IN + 32'sd1) / 32'sd2,
    localparam int W_OUT = ((W_IN + 32'sd1) > W_CAP) ? W_CAP : (W_IN + 32'sd1)
)(
    input  logic                     clock,
    input  logic [N_IN*W_IN-1:0]     i_data,
    output logic [N_OUT*W_OUT-1:0]   o_data
);

    localparam int W_PAD = 32'sd2 * N_OUT * W_IN;

    logic [W_PAD-1:0]       w_pad;
    logic [N_OUT*W_OUT-1:0] w_sum;
    logic [N_OUT*W_OUT-1:0] r_sum;

    assign w_pad = W_PAD'(i_data);

    // Pairwise sums of the (zero-padded) input partial sums.
    always_comb begin
        w_sum = '0;
        for (int g = 32'sd0; g < N_OUT; g++) begin
            w_sum[g*W_OUT +: W_OUT] = W_OUT'(w_pad[(32'sd2*g)*W_IN +: W_IN])
                                    + W_OUT'(w_pad[(32'sd2*g+32'sd1)*W_IN +: W_IN]);
        end
    end

    // Pipeline register for this level; data path carries no reset.
    always_ff @(posedge clock) begin
        r_sum <= w_sum;
    end

    assign o_data = r_sum;

endmodule

// File: rtl/vpf_count_pipe.sv
// Pipelined VPF hit counter with overflow flag and overflow-event tally.
// Stage 0 captures the VPF vector on latch_i, stage 1 popcounts 6-bit groups,
// L registered adder levels reduce to one count, and an output stage registers
// cnt_o/overflow_o/valid_o together. A shift register of latch_i tags which
// output cycles carry a real sample.
// Optional feature macro: VPF_COUNT_PEAK_HOLD_EN enables the peak_o
// max-hold register; without it peak_o is tied to zero.
module vpf_count_pipe
    import vpf_count_pkg::*;
#(
    parameter  int SIZE      = 768,
    parameter  int OVF_CNT_W = 16,
    localparam int CNTW      = cnt_width(SIZE)
)(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 latch_i,
    input  logic [SIZE-1:0]      vpfs_i,
    input  logic [CNTW-1:0]      thresh_i,
    input  logic                 clear_i,
    output logic [CNTW-1:0]      cnt_o,
    output logic                 valid_o,
    output logic                 overflow_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o,
    output logic [CNTW-1:0]      peak_o
);

    localparam int NG   = (SIZE + GRP_W - 32'sd1) / GRP_W;
    localparam int L    = tree_levels(NG);
    localparam int PADW = NG * GRP_W;

    logic [PADW-1:0]      w_vpfs_pad;
    logic [PADW-1:0]      r_vpfs;
    logic [NG*PC_W-1:0]   w_pc;
    logic [NG*PC_W-1:0]   r_pc;
    logic [CNTW-1:0]      w_tree_cnt;
    logic [L+1:0]         r_vld;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_ovf;
    logic                 r_valid;
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // Unused top bits of the last group count as zero hits.
    assign w_vpfs_pad = PADW'(vpfs_i);

    // Stage 0: capture the vector on latch_i (ignored in reset), otherwise hold.
    always_ff @(posedge clock) begin
        if (reset_n && latch_i) begin
            r_vpfs <= w_vpfs_pad;
        end else begin
            r_vpfs <= r_vpfs;
        end
    end

    // Per-group popcount of the captured vector.
    always_comb begin
        w_pc = '0;
        for (int g = 32'sd0; g < NG; g++) begin
            w_pc[g*PC_W +: PC_W] = count1s(r_vpfs[g*GRP_W +: GRP_W]);
        end
    end

    // Stage 1: register group popcounts.
    always_ff @(posedge clock) begin
        r_pc <= w_pc;
    end

    // Adder tree: level k reduces grp_count(NG,k) sums to grp_count(NG,k+1).
    if (L == 32'sd0) begin : gen_no_tree
        assign w_tree_cnt = CNTW'(r_pc);
    end else begin : gen_tree
        for (genvar k = 0; k < L; k++) begin : gen_lvl
            localparam int NI = grp_count(NG, k);
            localparam int WI = lvl_width(k, CNTW);
            localparam int NO = grp_count(NG, k + 32'sd1);
            localparam int WO = lvl_width(k + 32'sd1, CNTW);

            logic [NI*WI-1:0] w_in;
            logic [NO*WO-1:0] w_out;

            if (k == 0) begin : gen_src
                assign w_in = r_pc;
            end else begin : gen_src
                assign w_in = gen_lvl[k-1].w_out;
            end

            vpf_add_level #(
                .N_IN  (NI),
                .W_IN  (WI),
                .W_CAP (CNTW)
            ) u_add_level (
                .clock  (clock),
                .i_data (w_in),
                .o_data (w_out)
            );
        end
        assign w_tree_cnt = CNTW'(gen_lvl[L-1].w_out);
    end

    // Valid tag shift register aligned with the data stages; cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[L:0], latch_i};
        end
    end

    // Output stage: count, overflow and valid registered together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (r_vld[L+1]) begin
            r_cnt   <= w_tree_cnt;
            r_ovf   <= (w_tree_cnt > thresh_i);
            r_valid <= 1'b1;
        end else begin
            r_cnt   <= r_cnt;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    // Saturating tally of overflowing samples; clear beats a coincident count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else if (clear_i) begin
            r_ovf_cnt <= '0;
        end else if (r_valid && r_ovf && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
            r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1'b1);
        end else begin
            r_ovf_cnt <= r_ovf_cnt;
        end
    end

`ifdef VPF_COUNT_PEAK_HOLD_EN
    logic [CNTW-1:0] r_peak;

    // Peak hold: track the largest valid count since the last clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_peak <= '0;
        end else if (clear_i) begin
            r_peak <= '0;
        end else if (r_valid && (r_cnt > r_peak)) begin
            r_peak <= r_cnt;
        end else begin
            r_peak <= r_peak;
        end
    end

    assign peak_o = r_peak;
`else
    assign peak_o = '0;
`endif

    assign cnt_o      = r_cnt;
    assign overflow_o = r_ovf;
    assign valid_o    = r_valid;
    assign ovf_cnt_o  = r_ovf_cnt;

endmodule
